// File: rtl/spi_oled_tx_pkg.sv
// Shared types and constants for the SPI OLED transmitter.
package spi_oled_pkg;

    typedef enum logic [2:0] {
        ST_PRE,
        ST_RES_LO,
        ST_POST,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    localparam logic CPOL_LOW  = 1'b0;
    localparam logic CPOL_HIGH = 1'b1;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // Width of a counter that must reach max_val without wrapping.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_oled_tx_if.sv
// Word handshake between a command/data producer and the SPI OLED transmitter.
interface spi_oled_tx_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_dc;
    logic              tx_last;

    modport master (output tx_valid, tx_data, tx_dc, tx_last, input tx_ready);
    modport slave  (input tx_valid, tx_data, tx_dc, tx_last, output tx_ready);
endinterface

// File: rtl/spi_tick_gen.sv
// Half-period strobe for the SPI clock: one-cycle pulse every CLK_DIV enabled cycles.
module spi_tick_gen
    import spi_oled_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int           CW = cnt_w(CLK_DIV - 1);
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = (cnt_q == TC) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_oled_tx.sv
// Write-only SPI master for OLED panels: panel reset sequencing, then MSB-first
// words with per-word D/C and optional CS release.
module spi_oled_tx
    import spi_oled_pkg::*;
#(
    parameter int   DATA_W       = 8,
    parameter int   CLK_DIV      = 4,
    parameter logic CPOL         = CPOL_HIGH,
    parameter int   RES_PRE_CYC  = 100000,
    parameter int   RES_LOW_CYC  = 100000,
    parameter int   RES_POST_CYC = 100000,
    parameter int   CS_GAP       = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    spi_oled_tx_if.slave  tx,
    output logic          init_done,
    output logic          busy,
    output logic          spi_clk,
    output logic          spi_mosi,
    output logic          spi_dc,
    output logic          spi_cs,
    output logic          spi_res
);
    localparam int RES_MAX = (RES_PRE_CYC > RES_LOW_CYC)
                           ? ((RES_PRE_CYC > RES_POST_CYC) ? RES_PRE_CYC : RES_POST_CYC)
                           : ((RES_LOW_CYC > RES_POST_CYC) ? RES_LOW_CYC : RES_POST_CYC);
    localparam int RW = cnt_w(RES_MAX - 1);
    localparam int HW = cnt_w(2 * DATA_W - 1);
    localparam int GW = cnt_w(CS_GAP - 1);

    localparam logic [RW-1:0] PRE_TC  = RW'(RES_PRE_CYC - 1);
    localparam logic [RW-1:0] LOW_TC  = RW'(RES_LOW_CYC - 1);
    localparam logic [RW-1:0] POST_TC = RW'(RES_POST_CYC - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(2 * DATA_W - 1);
    localparam logic [GW-1:0] GAP_TC  = GW'(CS_GAP - 1);

    state_e            state_q, state_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              last_q, last_d;
    logic              init_done_q, init_done_d;
    logic              clk_q, clk_d;
    logic              dc_q, dc_d;
    logic              cs_q, cs_d;
    logic              res_q, res_d;

    logic accept;
    logic tick;

    assign tx.tx_ready = (state_q == ST_IDLE) && init_done_q;
    assign accept      = tx.tx_valid && tx.tx_ready;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (accept),
        .en      (state_q == ST_SHIFT),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q     <= ST_PRE;
            rcnt_q      <= '0;
            hcnt_q      <= '0;
            gcnt_q      <= '0;
            sr_q        <= '0;
            last_q      <= 1'b0;
            init_done_q <= 1'b0;
            clk_q       <= CPOL;
            dc_q        <= DC_CMD;
            cs_q        <= 1'b1;
            res_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            hcnt_q      <= hcnt_d;
            gcnt_q      <= gcnt_d;
            sr_q        <= sr_d;
            last_q      <= last_d;
            init_done_q <= init_done_d;
            clk_q       <= clk_d;
            dc_q        <= dc_d;
            cs_q        <= cs_d;
            res_q       <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PRE:    if (rcnt_q == PRE_TC)  state_d = ST_RES_LO;
            ST_RES_LO: if (rcnt_q == LOW_TC)  state_d = ST_POST;
            ST_POST:   if (rcnt_q == POST_TC) state_d = ST_IDLE;
            ST_IDLE:   if (accept)            state_d = ST_SHIFT;
            ST_SHIFT:  if (tick && hcnt_q == H_LAST) state_d = last_q ? ST_GAP : ST_IDLE;
            ST_GAP:    if (gcnt_q == GAP_TC)  state_d = ST_IDLE;
            default:                          state_d = ST_PRE;
        endcase
    end

    always_comb begin
        rcnt_d      = '0;
        hcnt_d      = hcnt_q;
        gcnt_d      = '0;
        sr_d        = sr_q;
        last_d      = last_q;
        dc_d        = dc_q;
        cs_d        = cs_q;
        clk_d       = clk_q;
        res_d       = (state_d != ST_RES_LO);
        init_done_d = init_done_q | ((state_q == ST_POST) && (state_d == ST_IDLE));
        unique case (state_q)
            ST_PRE, ST_RES_LO, ST_POST: begin
                if (state_d == state_q) rcnt_d = rcnt_q + RW'(1);
            end
            ST_IDLE: begin
                if (accept) begin
                    sr_d   = tx.tx_data;
                    dc_d   = tx.tx_dc;
                    last_d = tx.tx_last;
                    cs_d   = 1'b0;
                    clk_d  = CPOL;
                    hcnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    clk_d = ~clk_q;
                    if (hcnt_q == H_LAST) begin
                        // Final trailing edge: MOSI keeps the last bit, CS follows tx_last.
                        hcnt_d = '0;
                        cs_d   = last_q;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                        if (hcnt_q[0]) sr_d = sr_q << 1;
                    end
                end
            end
            ST_GAP: begin
                if (state_d == state_q) gcnt_d = gcnt_q + GW'(1);
            end
            default: ;
        endcase
    end

    assign init_done = init_done_q;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign spi_clk   = clk_q;
    assign spi_mosi  = sr_q[DATA_W-1];
    assign spi_dc    = dc_q;
    assign spi_cs    = cs_q;
    assign spi_res   = res_q;
endmodule

// File: tb/tb_spi_oled_tx.sv
// Directed bench: reset sequence, single word, burst, data stability, mid-word reset, wide word.
module tb_spi_oled_tx;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    spi_oled_tx_if #(.DATA_W(8))  tx1 ();
    spi_oled_tx_if #(.DATA_W(16)) tx2 ();

    logic init1, busy1, clk1, mosi1, dc1, cs1, res1;
    logic init2, busy2, clk2, mosi2, dc2, cs2, res2;

    spi_oled_tx #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .RES_PRE_CYC(10),
                  .RES_LOW_CYC(10), .RES_POST_CYC(10), .CS_GAP(2)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx(tx1),
        .init_done(init1), .busy(busy1), .spi_clk(clk1), .spi_mosi(mosi1),
        .spi_dc(dc1), .spi_cs(cs1), .spi_res(res1));

    spi_oled_tx #(.DATA_W(16), .CLK_DIV(1), .CPOL(1'b1), .RES_PRE_CYC(10),
                  .RES_LOW_CYC(10), .RES_POST_CYC(10), .CS_GAP(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx(tx2),
        .init_done(init2), .busy(busy2), .spi_clk(clk2), .spi_mosi(mosi2),
        .spi_dc(dc2), .spi_cs(cs2), .spi_res(res2));

    int n_chk = 0, n_pass = 0;
    int cyc = 0, acc_cyc = 0, acc2_cyc = 0;
    int rdy_at, rdy2_at, cs_lo, cs2_lo, cs_run, cs_run_max, nrise, n2rise, busy_n;
    logic [31:0] rbits, r2bits;
    logic dc_or, dc2_and, prev_clk, prev_mosi, prev2_clk, prev2_mosi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        rdy_at = -1; rdy2_at = -1; cs_lo = 0; cs2_lo = 0; cs_run = 0; cs_run_max = 0;
        nrise = 0; n2rise = 0; busy_n = 0; rbits = '0; r2bits = '0;
        dc_or = 1'b0; dc2_and = 1'b1;
        prev_clk = clk1; prev_mosi = mosi1; prev2_clk = clk2; prev2_mosi = mosi2;
        acc_cyc = cyc; acc2_cyc = cyc;
    endtask

    // One clock; samples both DUTs 1 time unit after the edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (!prev_clk && clk1) begin rbits = {rbits[30:0], prev_mosi}; nrise++; end
        prev_clk = clk1; prev_mosi = mosi1;
        if (!cs1) begin
            cs_lo++; cs_run++; dc_or |= dc1;
            if (cs_run > cs_run_max) cs_run_max = cs_run;
        end else cs_run = 0;
        if (busy1) busy_n++;
        if (tx1.tx_ready && rdy_at < 0) rdy_at = cyc - acc_cyc;
        if (!prev2_clk && clk2) begin r2bits = {r2bits[30:0], prev2_mosi}; n2rise++; end
        prev2_clk = clk2; prev2_mosi = mosi2;
        if (!cs2) begin cs2_lo++; dc2_and &= dc2; end
        if (tx2.tx_ready && rdy2_at < 0) rdy2_at = cyc - acc2_cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_rdy1();
        for (int i = 0; i < 200 && !tx1.tx_ready; i++) step();
        if (!tx1.tx_ready) chk("rdy1_timeout", 32'(tx1.tx_ready), 32'd1);
    endtask

    task automatic send1(input logic [7:0] d, input logic dc, input logic last);
        wait_rdy1();
        clear_mon();
        tx1.tx_valid = 1'b1; tx1.tx_data = d; tx1.tx_dc = dc; tx1.tx_last = last;
        step();
        tx1.tx_valid = 1'b0;
    endtask

    // Called with reset asserted; releases it and checks the 10/10/10 panel reset.
    task automatic reset_seq(input string tag);
        int first_lo, first_hi, first_done, bad;
        first_lo = -1; first_hi = -1; first_done = -1; bad = 0;
        tx1.tx_valid = 1'b1; tx1.tx_data = 8'h55; tx1.tx_dc = 1'b1; tx1.tx_last = 1'b1;
        sys_rst = 1'b1;
        clear_mon();
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) step();
            if (k == 30) tx1.tx_valid = 1'b0;
            if (!res1 && first_lo < 0) first_lo = k;
            if (res1 && first_lo >= 0 && first_hi < 0) first_hi = k;
            if (init1 && first_done < 0) first_done = k;
            if (k < 30 && (busy1 || !cs1 || tx1.tx_ready)) bad++;
        end
        chk({tag, "_res_lo_at"}, 32'(first_lo), 32'd10);
        chk({tag, "_res_hi_at"}, 32'(first_hi), 32'd20);
        chk({tag, "_init_at"}, 32'(first_done), 32'd30);
        chk({tag, "_ready30"}, 32'(tx1.tx_ready), 32'd1);
        chk({tag, "_early_valid_ignored"}, 32'(bad + nrise), 32'd0);
        step();
        chk({tag, "_idle_after"}, {30'd0, busy1, cs1}, 32'h1);
    endtask

    initial begin
        tx1.tx_valid = 1'b0; tx1.tx_data = '0; tx1.tx_dc = 1'b0; tx1.tx_last = 1'b0;
        tx2.tx_valid = 1'b0; tx2.tx_data = '0; tx2.tx_dc = 1'b0; tx2.tx_last = 1'b0;
        clear_mon();
        run(3);
        chk("reset_state", {24'd0, cs1, clk1, busy1, init1, tx1.tx_ready, res1, mosi1, dc1}, 32'hC4);
        reset_seq("seq1");

        // Single command word 0xAE, CS released after.
        send1(8'hAE, 1'b0, 1'b1);
        run(39);
        chk("ae_cs_low", 32'(cs_lo), 32'd32);
        chk("ae_nrise", 32'(nrise), 32'd8);
        chk("ae_bits", rbits, 32'hAE);
        chk("ae_dc", 32'(dc_or), 32'd0);
        chk("ae_busy_cyc", 32'(busy_n), 32'd34);
        chk("ae_ready_lat", 32'(rdy_at), 32'd35);

        // Burst 0x81 then 0xCF with valid held.
        wait_rdy1();
        clear_mon();
        tx1.tx_valid = 1'b1; tx1.tx_data = 8'h81; tx1.tx_dc = 1'b0; tx1.tx_last = 1'b0;
        step();
        tx1.tx_data = 8'hCF; tx1.tx_last = 1'b1;
        for (int i = 0; i < 100 && !tx1.tx_ready; i++) step();
        chk("burst_ready_lat", 32'(rdy_at), 32'd33);
        rdy_at = -1; acc_cyc = cyc;
        step();
        tx1.tx_valid = 1'b0;
        run(40);
        chk("burst_cs_run", 32'(cs_run_max), 32'd65);
        chk("burst_cs_low", 32'(cs_lo), 32'd65);
        chk("burst_bits", {16'd0, rbits[15:0]}, 32'h81CF);
        chk("burst_nrise", 32'(nrise), 32'd16);
        chk("burst_last_lat", 32'(rdy_at), 32'd35);

        // Input changes mid-word must not leak into the transfer.
        send1(8'h00, 1'b0, 1'b1);
        run(2);
        tx1.tx_data = 8'hFF; tx1.tx_dc = 1'b1;
        run(38);
        chk("stable_bits", rbits, 32'h0);
        chk("stable_nrise", 32'(nrise), 32'd8);
        chk("stable_dc", 32'(dc_or), 32'd0);

        // Reset in the middle of a word.
        send1(8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 100 && nrise < 4; i++) step();
        chk("midrst_reached_bit4", 32'(nrise), 32'd4);
        sys_rst = 1'b0;
        step();
        chk("midrst_state", {24'd0, cs1, clk1, busy1, init1, tx1.tx_ready, res1, mosi1, dc1}, 32'hC4);
        reset_seq("seq2");

        // Wide word on the CLK_DIV=1 instance.
        for (int i = 0; i < 200 && !tx2.tx_ready; i++) step();
        chk("w16_ready", 32'(tx2.tx_ready), 32'd1);
        clear_mon();
        tx2.tx_valid = 1'b1; tx2.tx_data = 16'h1234; tx2.tx_dc = 1'b1; tx2.tx_last = 1'b1;
        step();
        tx2.tx_valid = 1'b0;
        run(40);
        chk("w16_cs_low", 32'(cs2_lo), 32'd32);
        chk("w16_nrise", 32'(n2rise), 32'd16);
        chk("w16_bits", {16'd0, r2bits[15:0]}, 32'h1234);
        chk("w16_dc", 32'(dc2_and), 32'd1);
        chk("w16_ready_lat", 32'(rdy2_at), 32'd35);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_oled_tx.md
SPI_OLED_TX -- requirements
Module: spi_oled_tx

Interface
REQ-001 SHALL provide parameter: DATA_W, 8, bits per SPI word (legal 1..32).
REQ-002 SHALL provide parameter: CLK_DIV, 4, sys_clk cycles per SPI half-period (legal >=1).
REQ-003 SHALL provide parameter: CPOL, 1, idle level of spi_clk (CPHA fixed 0: data valid before leading edge).
REQ-004 SHALL provide parameter: RES_PRE_CYC, 100000, cycles spi_res held high before reset pulse.
REQ-005 SHALL provide parameter: RES_LOW_CYC, 100000, cycles spi_res held low.
REQ-006 SHALL provide parameter: RES_POST_CYC, 100000, cycles spi_res high before init_done.
REQ-007 SHALL provide parameter: CS_GAP, 2, cycles spi_cs stays high after a last word (legal >=1).
REQ-008 SHALL have ports: sys_clk in 1 system clock; sys_rst in 1 synchronous active-low reset.
REQ-009 SHALL have ports: tx_valid in 1 word offered; tx_ready out 1 word accepted when both high; tx_data in DATA_W word, MSB first; tx_dc in 1 D/C level for word (0 cmd, 1 data); tx_last in 1 release CS after word.
REQ-010 SHALL have ports: init_done out 1 panel reset sequence complete; busy out 1 word shifting or CS gap active.
REQ-011 SHALL have ports: spi_clk, spi_mosi, spi_dc, spi_cs, spi_res, all out 1, registered.

Function
REQ-012 SHALL run FSM states PRE, RES_LO, POST, IDLE, SHIFT, GAP; reset enters PRE.
REQ-013 PRE: spi_res=1 for RES_PRE_CYC cycles -> RES_LO; RES_LO: spi_res=0 for RES_LOW_CYC -> POST; POST: spi_res=1 for RES_POST_CYC -> IDLE with init_done=1 (sticky until reset).
REQ-014 tx_ready SHALL be 1 only in IDLE with init_done=1; tx_valid outside that is ignored, no side effects.
REQ-015 On accept (cycle T) SHALL latch tx_data/tx_dc/tx_last; at T+1 spi_cs=0, spi_dc=tx_dc, spi_mosi=tx_data[DATA_W-1], spi_clk=CPOL, state SHIFT.
REQ-016 SHIFT: spi_clk SHALL toggle every CLK_DIV cycles; leading edge at T+1+CLK_DIV; next bit driven on each trailing edge; DATA_W full periods total (2*CLK_DIV*DATA_W cycles), ending with spi_clk=CPOL.
REQ-017 After final trailing edge: tx_last=0 -> IDLE with spi_cs held 0 (burst); tx_last=1 -> GAP, spi_cs=1, for CS_GAP cycles, then IDLE.
REQ-018 Accept-to-next-tx_ready latency SHALL be 2*CLK_DIV*DATA_W+1 cycles (burst) or 2*CLK_DIV*DATA_W+CS_GAP+1 (last).
REQ-019 tx_data/tx_dc changes during SHIFT/GAP SHALL not affect the transfer in progress.
REQ-020 busy SHALL be 1 in SHIFT and GAP, 0 otherwise.
REQ-021 Counters SHALL be sized $clog2 of their maximum + 1; no wrap before terminal count; terminal count compare is equality.
REQ-022 spi_mosi SHALL hold last driven bit in IDLE/GAP.

Reset
REQ-023 sys_rst=0 at any sys_clk edge, including mid-SHIFT or mid-RES_LO, SHALL on that edge force: spi_clk=CPOL, spi_mosi=0, spi_dc=0, spi_cs=1, spi_res=1, tx_ready=0, busy=0, init_done=0, all counters 0, state PRE.
REQ-024 Releasing reset SHALL restart the full panel reset sequence; no partial word is resumed.

Structure
REQ-025 Package spi_oled_pkg SHALL hold the FSM state enum and CPOL/D-C encoding constants.
REQ-026 Sub-module spi_tick_gen SHALL produce a one-cycle half-period tick every CLK_DIV cycles, cleared on entry to SHIFT; all other logic in spi_oled_tx.

Verification (DATA_W=8, CLK_DIV=2, CPOL=1, RES_*_CYC=10, CS_GAP=2)
REQ-027 Release reset -> spi_res 1 for 10, 0 for 10, 1 for 10 cycles; init_done=1 and tx_ready=1 at cycle 30; tx_valid during 0..29 ignored.
REQ-028 Send 0xAE dc=0 last=1 -> spi_cs low 32 cycles, 8 rising edges sample 1,0,1,0,1,1,1,0, spi_dc=0, tx_ready again 35 cycles after accept.
REQ-029 Burst 0x81 (last=0) then 0xCF (last=1), valid held -> spi_cs stays 0 across both words (64+1 cycles), rises only after 0xCF, then 2-cycle gap.
REQ-030 Change tx_data to 0xFF 3 cycles after accepting 0x00 -> all 8 sampled bits 0.
REQ-031 Assert sys_rst=0 at bit 4 of a word -> next edge spi_cs=1, spi_clk=1, busy=0, init_done=0; after release full 30-cycle reset sequence repeats.
REQ-032 CLK_DIV=1, DATA_W=16, send 0x1234 dc=1 -> 16 rising edges sample 0x1234, spi_cs low 32 cycles, spi_dc=1.
